mem_stage: RTL

//  Memory-access stage of the 5-stage 16-bit pipeline, between EX and WB.

---
 rtl/mem_stage.sv | 94 +++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory-access stage of the 16-bit 5-stage pipeline (between EX and WB).
// Owns the data memory, commits stores, performs loads and registers the
// MEM/WB pipeline word. Optional load/store statistics counters are built
// when MEM_STAT_EN is defined.
module mem_stage #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [2*DATA_WIDTH+5:0]   pipeline_ex_i,
    input  logic                      stall_i,
    input  logic                      flush_i,
    output logic [2*DATA_WIDTH+4:0]   pipeline_re_o,
`ifdef MEM_STAT_EN
    output logic [15:0]               ld_cnt_o,
    output logic [15:0]               st_cnt_o,
`endif
    output logic [2:0]                mem_op_dest
);

    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
    localparam int unsigned EX_W   = 2 * DATA_WIDTH + 6;
    localparam int unsigned RE_W   = 2 * DATA_WIDTH + 5;
    localparam int unsigned CNT_W  = 16;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] store_data;
    logic                  mem_wr_en;
    logic                  wb_en;
    logic [2:0]            wb_dest;
    logic                  wb_result_mux;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  advance;
    logic                  commit;

    // Unpack the EX/MEM word and decide whether this edge advances the stage
    always_comb begin
        alu_result    = pipeline_ex_i[EX_W-1 -: DATA_WIDTH];
        store_data    = pipeline_ex_i[DATA_WIDTH+5 -: DATA_WIDTH];
        mem_wr_en     = pipeline_ex_i[5];
        wb_en         = pipeline_ex_i[4];
        wb_dest       = pipeline_ex_i[3:1];
        wb_result_mux = pipeline_ex_i[0];
        addr          = alu_result[ADDR_WIDTH-1:0];
        rd_data       = mem[addr];
        advance       = rst_n && !flush_i && !stall_i;
        commit        = advance && mem_wr_en;
    end

    assign mem_op_dest = wb_dest;

    // Data memory write port; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[addr] <= store_data;
        end
    end

    // MEM/WB pipeline register: reset > flush > stall > advance
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipeline_re_o <= RE_W'(0);
        end else if (flush_i) begin
            pipeline_re_o <= RE_W'(0);
        end else if (!stall_i) begin
            pipeline_re_o <= {alu_result, rd_data, wb_en, wb_dest, wb_result_mux};
        end
    end

`ifdef MEM_STAT_EN
    logic load_fire;
    assign load_fire = advance && wb_en && wb_result_mux;

    // Saturating counters of committed stores and executed loads
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_cnt_o <= CNT_W'(0);
            ld_cnt_o <= CNT_W'(0);
        end else begin
            if (commit && (st_cnt_o != {CNT_W{1'b1}})) begin
                st_cnt_o <= st_cnt_o + CNT_W'(1);
            end
            if (load_fire && (ld_cnt_o != {CNT_W{1'b1}})) begin
                ld_cnt_o <= ld_cnt_o + CNT_W'(1);
            end
        end
    end
`endif

endmodule
